// File: rtl/regfile_wb_ctrl.sv
// ============================================================================
// Module   : regfile_wb_ctrl
// Brief    : Register-file write-port arbiter (ALU / LSU) with pending-write
//            scoreboard for RAW/WAW issue stalls. Define WB_FIXED_PRIO_EN for
//            fixed LSU-priority arbitration instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb0_valid,
    input  logic [ADDR_W-1:0]        wb0_rd,
    input  logic [DATA_W-1:0]        wb0_data,
    output logic                     wb0_ready,
    input  logic                     wb1_valid,
    input  logic [ADDR_W-1:0]        wb1_rd,
    input  logic [DATA_W-1:0]        wb1_data,
    output logic                     wb1_ready,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic [ADDR_W-1:0]        issue_rs1,
    input  logic [ADDR_W-1:0]        issue_rs2,
    output logic                     issue_stall,
    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int NREG = 1 << ADDR_W;

    logic                w_gnt0;
    logic                w_gnt1;
    logic [ADDR_W-1:0]   w_xfer_rd;
    logic [DATA_W-1:0]   w_xfer_data;
    logic                w_wr;
    logic                w_stall;
    logic                w_issue_fire;
    logic [NREG-1:0]     w_busy_full;

    logic                we_q;
    logic [ADDR_W-1:0]   dest_q;
    logic [DATA_W-1:0]   data_q;
    logic [NREG-1:1]     busy_q;
    logic [NREG-1:1]     busy_d;

`ifdef WB_FIXED_PRIO_EN
    // LSU always wins a conflict; no arbitration history needed.
    assign w_gnt1 = wb1_valid;
    assign w_gnt0 = wb0_valid & ~wb1_valid;
`else
    logic last_grant_q;
    logic last_grant_d;

    // Conflicts go to the source not granted last; a lone request always wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (wb0_valid && wb1_valid) begin
            if (last_grant_q) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else begin
            w_gnt0 = wb0_valid;
            w_gnt1 = wb1_valid;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (w_gnt1) begin
            last_grant_d = 1'b1;
        end else if (w_gnt0) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign wb0_ready   = w_gnt0;
    assign wb1_ready   = w_gnt1;
    assign w_xfer_rd   = w_gnt1 ? wb1_rd   : wb0_rd;
    assign w_xfer_data = w_gnt1 ? wb1_data : wb0_data;
    // Writes to x0 are accepted but never reach the register file.
    assign w_wr        = (w_gnt0 | w_gnt1) && (w_xfer_rd != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= w_wr;
            if (w_wr) begin
                dest_q <= w_xfer_rd;
                data_q <= w_xfer_data;
            end
        end
    end

    assign w_busy_full  = {busy_q, 1'b0};
    assign w_stall      = w_busy_full[issue_rs1] | w_busy_full[issue_rs2] | w_busy_full[issue_rd];
    assign w_issue_fire = issue_valid & ~w_stall;

    // Set has priority over clear so a re-issue during the final write keeps the bit.
    generate
        for (genvar i = 1; i < NREG; i++) begin : g_busy
            assign busy_d[i] = (w_issue_fire && (issue_rd == ADDR_W'(i)))
                             | (busy_q[i] & ~(we_q && (dest_q == ADDR_W'(i))));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign issue_stall    = w_stall;
    assign reg_write_en   = we_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;
    assign busy_vec       = w_busy_full;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Brief    : Scoreboard bench for regfile_wb_ctrl: directed stimulus pushes
//            expected register writes, a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb0_valid, wb1_valid, issue_valid;
    logic [4:0]  wb0_rd, wb1_rd, issue_rd, issue_rs1, issue_rs2;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready, issue_stall, reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
    logic [31:0] busy_vec;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    wr_t sbq[$];
    wr_t mon_e;
    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    int  exp_g[4];

    regfile_wb_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb0_valid      (wb0_valid),
        .wb0_rd         (wb0_rd),
        .wb0_data       (wb0_data),
        .wb0_ready      (wb0_ready),
        .wb1_valid      (wb1_valid),
        .wb1_rd         (wb1_rd),
        .wb1_data       (wb1_data),
        .wb1_ready      (wb1_ready),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_stall    (issue_stall),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .busy_vec       (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t w;
        w.rd = rd;
        w.d  = d;
        sbq.push_back(w);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every registered write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && reg_write_en) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", 64'(reg_write_dest), 64'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk("wr_dest", 64'(reg_write_dest), 64'(mon_e.rd));
                chk("wr_data", 64'(reg_write_data), 64'(mon_e.d));
            end
        end
    end

    initial begin
`ifdef WB_FIXED_PRIO_EN
        exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`else
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
        reset_n = 1'b0;
        wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;

        #12;
        chk("rst_we",     64'(reg_write_en),   64'h0);
        chk("rst_dest",   64'(reg_write_dest), 64'h0);
        chk("rst_data",   64'(reg_write_data), 64'h0);
        chk("rst_busy",   64'(busy_vec),       64'h0);
        chk("rst_rdy0",   64'(wb0_ready),      64'h0);
        chk("rst_rdy1",   64'(wb1_ready),      64'h0);
        chk("rst_stall",  64'(issue_stall),    64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single write from the ALU.
        cyc();
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        push_wr(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("single_rdy0", 64'(wb0_ready), 64'h1);
        chk("single_rdy1", 64'(wb1_ready), 64'h0);
        cyc();
        wb0_valid = 1'b0;
        @(negedge clk);
        chk("single_we", 64'(reg_write_en), 64'h1);
        cyc();
        @(negedge clk);
        chk("single_one_cycle", 64'(reg_write_en), 64'h0);

        // Fresh reset so last_grant starts at 1, then a 4-cycle conflict.
        cyc();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i] == 1) push_wr(5'd4, 32'h22);
            else               push_wr(5'd3, 32'h11);
            @(negedge clk);
            chk($sformatf("conf_rdy0_%0d", i), 64'(wb0_ready), (exp_g[i] == 0) ? 64'h1 : 64'h0);
            chk($sformatf("conf_rdy1_%0d", i), 64'(wb1_ready), (exp_g[i] == 1) ? 64'h1 : 64'h0);
            cyc();
        end

        // Write to x0 is accepted and dropped.
        wb0_valid = 1'b0;
        wb1_rd = 5'd0; wb1_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("x0_rdy1", 64'(wb1_ready), 64'h1);
        chk("x0_rdy0", 64'(wb0_ready), 64'h0);
        cyc();
        wb1_valid = 1'b0;
        @(negedge clk);
        chk("x0_no_write", 64'(reg_write_en), 64'h0);

        // RAW on x7.
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("raw_issue_nostall", 64'(issue_stall), 64'h0);
        cyc();
        issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd7;
        @(negedge clk);
        chk("raw_stall",  64'(issue_stall), 64'h1);
        chk("raw_busy7",  64'(busy_vec),    64'h80);
        cyc();
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77;
        push_wr(5'd7, 32'h77);
        @(negedge clk);
        chk("raw_wb_rdy0", 64'(wb0_ready),   64'h1);
        chk("raw_stall_held", 64'(issue_stall), 64'h1);
        cyc();
        wb0_valid = 1'b0;
        @(negedge clk);
        chk("raw_we", 64'(reg_write_en), 64'h1);
        chk("raw_stall_during_we", 64'(issue_stall), 64'h1);
        cyc();
        @(negedge clk);
        chk("raw_stall_clear", 64'(issue_stall), 64'h0);
        chk("raw_busy_clear",  64'(busy_vec),    64'h0);

        // Same-edge set and clear of x9: set must win.
        issue_rs1 = 5'd0;
        cyc();
        wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h99;
        push_wr(5'd9, 32'h99);
        @(negedge clk);
        chk("same_rdy1", 64'(wb1_ready), 64'h1);
        cyc();
        wb1_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        chk("same_nostall", 64'(issue_stall), 64'h0);
        cyc();
        issue_valid = 1'b0; issue_rd = 5'd0;
        @(negedge clk);
        chk("same_busy9", 64'(busy_vec), 64'h200);

        // Asynchronous reset while a write is in flight and busy = 0x280.
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("mid_issue7", 64'(issue_stall), 64'h0);
        cyc();
        issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd9;
        wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h1234;
        push_wr(5'd1, 32'h1234);
        @(negedge clk);
        chk("mid_rdy0",  64'(wb0_ready),   64'h1);
        chk("mid_stall", 64'(issue_stall), 64'h1);
        cyc();
        wb0_valid = 1'b0;
        chk("mid_pre_we",   64'(reg_write_en), 64'h1);
        chk("mid_pre_busy", 64'(busy_vec),     64'h280);
        #2;
        reset_n = 1'b0;
        sbq.delete();
        #1;
        chk("mid_rst_we",    64'(reg_write_en),   64'h0);
        chk("mid_rst_dest",  64'(reg_write_dest), 64'h0);
        chk("mid_rst_busy",  64'(busy_vec),       64'h0);
        chk("mid_rst_stall", 64'(issue_stall),    64'h0);
        #3;
        reset_n = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", 64'(sbq.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
